spiso_scan_ctrl: RTL and testbench

Sequencer for the 24-bit serial-load parallel-in/serial-out wrapper shifter (`spiso_24bit`) in the IEEE 1500 wrapper datapath.
- Accepts parallel test patterns over a valid/ready handshake and drives the shifter's `load`, `shift_en`, `data_in` and clear.
- Issues the wrapper ShiftWR, UpdateWR and CaptureWR strobes aligned to the shifter's registered serial output.
- Deserialises the wrapper serial output (WSO) into a response word returned over a second valid/ready handshake.

---
 rtl/wrp1500_pkg.sv | 39 +++
 rtl/wso_sipo.sv | 45 ++++
 rtl/spiso_scan_ctrl.sv | 100 ++++++++++
 tb/tb_spiso_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrp1500_pkg.sv
// Shared types and constants for the IEEE 1500 wrapper shift sequencer.
package wrp1500_pkg;

  localparam int WRP_SIZE = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_UPDATE,
    ST_CAPTURE
  } wrp_state_e;

  // Strobe vector decoded from the controller state, one bit per strobe.
  localparam int STB_W           = 4;
  localparam int STB_LOAD_BIT    = 0;
  localparam int STB_SHIFT_BIT   = 1;
  localparam int STB_UPDATE_BIT  = 2;
  localparam int STB_CAPTURE_BIT = 3;

  localparam logic [STB_W-1:0] STB_NONE    = 4'b0000;
  localparam logic [STB_W-1:0] STB_LOAD    = 4'b0001;
  localparam logic [STB_W-1:0] STB_SHIFT   = 4'b0010;
  localparam logic [STB_W-1:0] STB_UPDATE  = 4'b0100;
  localparam logic [STB_W-1:0] STB_CAPTURE = 4'b1000;

  // Maps a state onto the strobes it drives; DRAIN and IDLE drive none.
  function automatic logic [STB_W-1:0] state_strobes(input wrp_state_e s);
    case (s)
      ST_LOAD:    return STB_LOAD;
      ST_SHIFT:   return STB_SHIFT;
      ST_UPDATE:  return STB_UPDATE;
      ST_CAPTURE: return STB_CAPTURE;
      default:    return STB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wso_sipo.sv
// Serial-in response register: collects SIZE wrapper serial-out bits and
// presents them as one word over a valid/ready handshake.
module wso_sipo #(
  parameter int SIZE  = 24,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            abort,
  input  logic            sample,
  input  logic            wso,
  input  logic            resp_ready,
  output logic            resp_valid,
  output logic [SIZE-1:0] resp_data
);

  logic [CNT_W-1:0] count;
  logic             last_sample;

  assign last_sample = (count == CNT_W'(SIZE - 1));

  // Right shift with the new bit entering the MSB, so the first bit ends in bit 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      resp_data  <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
    end else if (abort) begin
      resp_data  <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
    end else begin
      if (sample) begin
        resp_data <= {wso, resp_data[SIZE-1:1]};
        count     <= last_sample ? '0 : count + 1'b1;
      end
      if (sample && last_sample) begin
        resp_valid <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spiso_scan_ctrl.sv
// Sequencer for the 24-bit wrapper shifter: load, shift, drain, update,
// capture, with the wrapper serial output deserialised into a response word.
module spiso_scan_ctrl
  import wrp1500_pkg::*;
#(
  parameter int SIZE  = WRP_SIZE,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            abort,
  input  logic            pat_valid,
  output logic            pat_ready,
  input  logic [SIZE-1:0] pat_data,
  output logic [SIZE-1:0] sh_data_in,
  output logic            sh_load,
  output logic            sh_shift_en,
  output logic            sh_clr,
  output logic            wrp_shift_wr,
  output logic            wrp_update_wr,
  output logic            wrp_capture_wr,
  input  logic            wso,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_data
);

  wrp_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [STB_W-1:0] strobes;
  logic             accept;

  // A pending response blocks new patterns so it can never be overwritten.
  assign pat_ready = (state == ST_IDLE) && !resp_valid && !abort;
  assign accept    = pat_valid && pat_ready;

  assign strobes        = state_strobes(state);
  assign sh_load        = strobes[STB_LOAD_BIT];
  assign sh_shift_en    = strobes[STB_SHIFT_BIT];
  assign wrp_update_wr  = strobes[STB_UPDATE_BIT];
  assign wrp_capture_wr = strobes[STB_CAPTURE_BIT];

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE:    if (accept) state_next = ST_LOAD;
      ST_LOAD: begin
        state_next = ST_SHIFT;
        cnt_next   = '0;
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(SIZE - 1)) state_next = ST_DRAIN;
        else                         cnt_next   = cnt + 1'b1;
      end
      ST_DRAIN:   state_next = ST_UPDATE;
      ST_UPDATE:  state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // State, counter and registered shifter/wrapper controls.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sh_data_in   <= '0;
      wrp_shift_wr <= 1'b0;
      sh_clr       <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      // ShiftWR follows shift_en by one cycle, matching the shifter's registered output.
      wrp_shift_wr <= sh_shift_en && !abort;
      sh_clr       <= !abort;
      if (accept) sh_data_in <= pat_data;
    end
  end

  wso_sipo #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_sipo (
    .clk        (clk),
    .clr        (clr),
    .abort      (abort),
    .sample     (wrp_shift_wr),
    .wso        (wso),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

endmodule

// File: tb/tb_spiso_scan_ctrl.sv
// Bench for spiso_scan_ctrl with a behavioural shifter whose data_out is
// looped back to wso; responses are checked against a scoreboard queue.
module tb_spiso_scan_ctrl;

  localparam int SIZE = 24;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            abort = 1'b0;
  logic            pat_valid = 1'b0;
  logic            pat_ready;
  logic [SIZE-1:0] pat_data = '0;
  logic [SIZE-1:0] sh_data_in;
  logic            sh_load, sh_shift_en, sh_clr;
  logic            wrp_shift_wr, wrp_update_wr, wrp_capture_wr;
  logic            wso;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [SIZE-1:0] resp_data;

  logic [SIZE-1:0] sr = '0;
  logic            dout = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pop = -1;
  int n_resp   = 0;
  logic [SIZE-1:0] sb_q[$];

  spiso_scan_ctrl #(.SIZE(SIZE), .CNT_W(5)) dut (
    .clk            (clk),
    .clr            (clr),
    .abort          (abort),
    .pat_valid      (pat_valid),
    .pat_ready      (pat_ready),
    .pat_data       (pat_data),
    .sh_data_in     (sh_data_in),
    .sh_load        (sh_load),
    .sh_shift_en    (sh_shift_en),
    .sh_clr         (sh_clr),
    .wrp_shift_wr   (wrp_shift_wr),
    .wrp_update_wr  (wrp_update_wr),
    .wrp_capture_wr (wrp_capture_wr),
    .wso            (wso),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model: registered serial output, LSB first.
  always @(posedge clk) begin
    if (!clr || !sh_clr) begin
      sr   <= '0;
      dout <= 1'b0;
    end else if (sh_load) begin
      sr <= sh_data_in;
    end else if (sh_shift_en) begin
      dout <= sr[0];
      sr   <= {1'b0, sr[SIZE-1:1]};
    end
  end

  assign wso = dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (clr && resp_valid && resp_ready) begin
      last_pop = cyc;
      n_resp++;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got %06h, expected no response (cycle %0d)", resp_data, cyc);
      end else begin
        logic [SIZE-1:0] exp_d;
        exp_d = sb_q.pop_front();
        check("resp_data", 32'(resp_data), 32'(exp_d));
        $display("resp #%0d cycle %0d data=%06h expected=%06h", n_resp, cyc, resp_data, exp_d);
      end
    end
  end

  function automatic logic [7:0] status();
    return {pat_ready, sh_load, sh_shift_en, sh_clr,
            wrp_shift_wr, wrp_update_wr, wrp_capture_wr, resp_valid};
  endfunction

  // Offers a pattern and waits for the accept edge; returns in the LOAD cycle.
  task automatic send_pat(input logic [SIZE-1:0] p, input bit expect_resp, output int acc_cyc);
    int n;
    n = 0;
    pat_data  = p;
    pat_valid = 1'b1;
    @(negedge clk);
    while (!pat_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!pat_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      if (expect_resp) sb_q.push_back(p);
      $display("pattern %06h accepted cycle %0d", p, cyc);
    end
    @(posedge clk);
    #1 pat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !pat_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    int acc1, acc2, n, ones;
    logic [SIZE-1:0] got;
    logic [SIZE-1:0] pat_a;

    // Reset, then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", 32'(status()), 32'h90);
    check("reset_resp_data", 32'(resp_data), 32'd0);
    check("reset_sh_data_in", 32'(sh_data_in), 32'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_status", 32'(status()), 32'h90);

    // Single pattern with cycle-accurate strobe checks.
    @(posedge clk);
    #1;
    pat_a = 24'hA5_0F3C;
    send_pat(pat_a, 1'b1, acc1);
    @(negedge clk); // t+1
    check("load_strobe", 32'(sh_load), 32'd1);
    check("load_data_in", 32'(sh_data_in), 32'(pat_a));
    @(negedge clk); // t+2
    check("shift_en_first", 32'(sh_shift_en), 32'd1);
    check("shift_wr_lag", 32'(wrp_shift_wr), 32'd0);
    got  = '0;
    ones = 0;
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk); // t+3+k
      got[k] = dout;
      if (wrp_shift_wr) ones++;
    end
    check("data_out_bits", 32'(got), 32'(pat_a));
    check("shift_wr_len", 32'(ones), 32'd24);
    @(negedge clk); // t+27
    check("update_t27", 32'(wrp_update_wr), 32'd1);
    check("shift_wr_off_t27", 32'(wrp_shift_wr), 32'd0);
    check("resp_valid_t27", 32'(resp_valid), 32'd1);
    check("update_cycle", 32'(cyc - acc1), 32'd27);
    @(negedge clk); // t+28
    check("capture_t28", 32'(wrp_capture_wr), 32'd1);
    wait_idle();

    // Back-to-back; the period spans 30 cycles counting both accept cycles.
    @(posedge clk);
    #1;
    send_pat(24'h000001, 1'b1, acc1);
    send_pat(24'h800000, 1'b1, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd29);
    wait_idle();

    // Held response blocks new patterns; consume and offer coincide.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    send_pat(24'h3C_5A96, 1'b1, acc1);
    n = 0;
    while (!resp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("resp_wait_timeout", 32'(n >= 60), 32'd0);
    @(posedge clk);
    #1;
    pat_data  = 24'h12_3456;
    pat_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_pat_ready", 32'(pat_ready), 32'd0);
      check("hold_resp_data", 32'(resp_data), 32'h3C_5A96);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    send_pat(24'h12_3456, 1'b1, acc2);
    check("accept_after_consume", 32'(acc2 - last_pop), 32'd1);
    wait_idle();

    // Abort in the 10th SHIFT cycle.
    @(posedge clk);
    #1;
    send_pat(24'hFF_FFFF, 1'b0, acc1);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_in_shift", 32'(sh_shift_en), 32'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_status", 32'(status()), 32'h80);
    @(negedge clk);
    check("abort_clr_release", 32'(sh_clr), 32'd1);
    check("abort_data_out", 32'(dout), 32'd0);
    @(posedge clk);
    #1;
    send_pat(24'h5A_C3E1, 1'b1, acc1);
    wait_idle();

    // Asynchronous reset in the middle of SHIFT.
    @(posedge clk);
    #1;
    send_pat(24'h76_5432, 1'b0, acc1);
    repeat (5) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    check("clr_status", 32'(status()), 32'h90);
    check("clr_resp_data", 32'(resp_data), 32'd0);
    check("clr_sh_data_in", 32'(sh_data_in), 32'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
    send_pat(24'h0F_F0A5, 1'b1, acc1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("resp_count", 32'(n_resp), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
